// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: request/ack fetch FSM toward the memory controller,
// static next-PC prediction and a DEPTH-entry queue presented to the decoder.
module fetch_queue_unit #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    INST_WIDTH = 32,
   parameter int                    DEPTH      = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  rdy_in,
   output logic                  mc_req_out,
   output logic [ADDR_WIDTH-1:0] mc_addr_out,
   input  logic                  mc_done_in,
   input  logic [INST_WIDTH-1:0] mc_inst_in,
   input  logic                  flush_in,
   input  logic [ADDR_WIDTH-1:0] flush_pc_in,
   output logic                  dc_valid_out,
   input  logic                  dc_ready_in,
   output logic [INST_WIDTH-1:0] dc_inst_out,
   output logic [ADDR_WIDTH-1:0] dc_pc_out,
   output logic                  dc_pred_taken_out,
   output logic [ADDR_WIDTH-1:0] dc_pred_pc_out,
   output logic [1:0]            fsm_state_out
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   pc_q;
   logic                    mc_req_q;
   logic [ADDR_WIDTH-1:0]   mc_addr_q;
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]        count_q, count_d;

   logic [INST_WIDTH-1:0]   inst_mem [DEPTH];
   logic [ADDR_WIDTH-1:0]   pc_mem   [DEPTH];
   logic                    tk_mem   [DEPTH];
   logic [ADDR_WIDTH-1:0]   pp_mem   [DEPTH];

   logic [ADDR_WIDTH-1:0]   imm_j, imm_b, pred_pc;
   logic                    pred_taken, push, pop, not_empty;

   assign imm_j = {{(ADDR_WIDTH-21){mc_inst_in[31]}}, mc_inst_in[31], mc_inst_in[19:12],
                   mc_inst_in[20], mc_inst_in[30:21], 1'b0};
   assign imm_b = {{(ADDR_WIDTH-13){mc_inst_in[31]}}, mc_inst_in[31], mc_inst_in[7],
                   mc_inst_in[30:25], mc_inst_in[11:8], 1'b0};

   always_comb begin
      pred_taken = 1'b0;
      pred_pc    = pc_q + PC_STEP;
      case (mc_inst_in[6:0])
         7'b1101111: begin
            pred_taken = 1'b1;
            pred_pc    = pc_q + imm_j;
         end
         7'b1100011: begin
            if (mc_inst_in[31]) begin
               pred_taken = 1'b1;
               pred_pc    = pc_q + imm_b;
            end
         end
         default: ;
      endcase
   end

   // Decoder handshake: an entry transfers on a cycle where dc_valid_out and dc_ready_in
   // are both high; valid never depends on ready and is masked while rdy_in is low.
   assign not_empty    = (count_q != '0);
   assign dc_valid_out = not_empty & rdy_in;
   assign pop          = dc_valid_out & dc_ready_in & ~flush_in;
   assign push         = rdy_in & ~flush_in & (state_q == S_WAIT) & mc_done_in;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_in) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (push) begin
         inst_mem[wr_ptr_q] <= mc_inst_in;
         pc_mem[wr_ptr_q]   <= pc_q;
         tk_mem[wr_ptr_q]   <= pred_taken;
         pp_mem[wr_ptr_q]   <= pred_pc;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         mc_req_q  <= 1'b0;
         mc_addr_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else if (rdy_in) begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (flush_in) begin
            pc_q <= flush_pc_in;
            // An outstanding request must still complete; its response is dropped.
            if (state_q == S_WAIT || state_q == S_DISCARD) begin
               if (mc_done_in) begin
                  state_q  <= S_IDLE;
                  mc_req_q <= 1'b0;
               end else begin
                  state_q  <= S_DISCARD;
               end
            end else begin
               state_q <= S_IDLE;
            end
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (count_q != CNT_FULL) begin
                     mc_req_q  <= 1'b1;
                     mc_addr_q <= pc_q;
                     state_q   <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (mc_done_in) begin
                     mc_req_q <= 1'b0;
                     pc_q     <= pred_pc;
                     state_q  <= S_IDLE;
                  end
               end
               S_DISCARD: begin
                  if (mc_done_in) begin
                     mc_req_q <= 1'b0;
                     state_q  <= S_IDLE;
                  end
               end
               default: begin
                  mc_req_q <= 1'b0;
                  state_q  <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign mc_req_out        = mc_req_q;
   assign mc_addr_out       = mc_addr_q;
   assign dc_inst_out       = not_empty ? inst_mem[rd_ptr_q] : '0;
   assign dc_pc_out         = not_empty ? pc_mem[rd_ptr_q]   : '0;
   assign dc_pred_taken_out = not_empty ? tk_mem[rd_ptr_q]   : 1'b0;
   assign dc_pred_pc_out    = not_empty ? pp_mem[rd_ptr_q]   : '0;
   assign fsm_state_out     = state_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: prediction vector table plus hand-written
// sequences for fill/backpressure, flush, discard, stall and asynchronous reset.
module tb_fetch_queue_unit;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] JUNK = 32'h0000_006F;

   logic        clk_in = 1'b0;
   logic        rst_n_in, rdy_in, mc_done_in, flush_in, dc_ready_in;
   logic [31:0] mc_inst_in, flush_pc_in;
   logic        mc_req_out, dc_valid_out, dc_pred_taken_out;
   logic [31:0] mc_addr_out, dc_inst_out, dc_pc_out, dc_pred_pc_out;
   logic [1:0]  fsm_state_out;

   fetch_queue_unit dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
      .mc_req_out(mc_req_out), .mc_addr_out(mc_addr_out),
      .mc_done_in(mc_done_in), .mc_inst_in(mc_inst_in),
      .flush_in(flush_in), .flush_pc_in(flush_pc_in),
      .dc_valid_out(dc_valid_out), .dc_ready_in(dc_ready_in),
      .dc_inst_out(dc_inst_out), .dc_pc_out(dc_pc_out),
      .dc_pred_taken_out(dc_pred_taken_out), .dc_pred_pc_out(dc_pred_pc_out),
      .fsm_state_out(fsm_state_out)
   );

   always #5 clk_in = ~clk_in;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [96:0] exp_q[$];
   logic [96:0] mon_e;
   bit          mon_en = 1'b1;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        taken;
      logic [31:0] pred;
   } vec_t;
   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_in);
   endtask

   task automatic wait_req();
      int n = 0;
      while (!mc_req_out && n < 100) begin
         tick();
         n++;
      end
      check("req_seen", {31'b0, mc_req_out}, 32'd1);
   endtask

   task automatic serve(input logic [31:0] addr, input logic [31:0] inst, input int lat);
      wait_req();
      check("req_addr", mc_addr_out, addr);
      for (int k = 0; k < lat; k++) begin
         tick();
         check("req_hold", {31'b0, mc_req_out}, 32'd1);
      end
      mc_done_in = 1'b1;
      mc_inst_in = inst;
      tick();
      mc_done_in = 1'b0;
      mc_inst_in = '0;
   endtask

   task automatic flush_with_done(input logic [31:0] target);
      wait_req();
      mc_done_in  = 1'b1;
      mc_inst_in  = JUNK;
      flush_in    = 1'b1;
      flush_pc_in = target;
      tick();
      mc_done_in  = 1'b0;
      flush_in    = 1'b0;
      mc_inst_in  = '0;
   endtask

   // Scoreboard: every accepted head entry must match the oldest expected entry.
   always begin
      @(negedge clk_in);
      #2;
      if (mon_en && dc_valid_out && dc_ready_in) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL pop_unexpected: got pc %h expected no entry", dc_pc_out);
         end else begin
            mon_e = exp_q.pop_front();
            check("pop_inst", dc_inst_out, mon_e[96:65]);
            check("pop_pc", dc_pc_out, mon_e[64:33]);
            check("pop_taken", {31'b0, dc_pred_taken_out}, {31'b0, mon_e[32]});
            check("pop_pred", dc_pred_pc_out, mon_e[31:0]);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit saw;
      vecs[0] = '{32'h0000_0010, 32'hFE00_0EE3, 1'b1, 32'h0000_000C};
      vecs[1] = '{32'h0000_0020, 32'h0080_006F, 1'b1, 32'h0000_0028};
      vecs[2] = '{32'h0000_0030, 32'h0000_0013, 1'b0, 32'h0000_0034};
      vecs[3] = '{32'h0000_0040, 32'h0020_8463, 1'b0, 32'h0000_0044};
      vecs[4] = '{32'h0000_0050, 32'hFFC0_80E7, 1'b0, 32'h0000_0054};
      vecs[5] = '{32'hFFFF_FFF8, 32'h0100_006F, 1'b1, 32'h0000_0008};
      vecs[6] = '{32'h0000_0004, 32'hFE00_0CE3, 1'b1, 32'hFFFF_FFFC};

      rst_n_in = 1'b0; rdy_in = 1'b1; mc_done_in = 1'b0; mc_inst_in = '0;
      flush_in = 1'b0; flush_pc_in = '0; dc_ready_in = 1'b0;
      repeat (2) tick();
      check("rst_req", {31'b0, mc_req_out}, 32'd0);
      check("rst_addr", mc_addr_out, 32'd0);
      check("rst_valid", {31'b0, dc_valid_out}, 32'd0);
      check("rst_inst", dc_inst_out, 32'd0);
      check("rst_pc", dc_pc_out, 32'd0);
      check("rst_state", {30'b0, fsm_state_out}, 32'd0);

      // Sequential fetch with the decoder always ready
      rst_n_in    = 1'b1;
      dc_ready_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({NOP, 32'(i * 4), 1'b0, 32'(i * 4 + 4)});
         serve(32'(i * 4), NOP, 2);
      end
      exp_q.push_back({32'hFE00_0EE3, 32'h10, 1'b1, 32'h0C});
      serve(32'h10, 32'hFE00_0EE3, 2);
      exp_q.push_back({NOP, 32'h0C, 1'b0, 32'h10});
      serve(32'h0C, NOP, 1);
      repeat (3) tick();
      check("seq_drained", 32'(exp_q.size()), 32'd0);
      dc_ready_in = 1'b0;

      // Prediction vectors, each fetched from a flush target
      for (int v = 0; v < 7; v++) begin
         flush_with_done(vecs[v].pc);
         check("vec_drop_valid", {31'b0, dc_valid_out}, 32'd0);
         serve(vecs[v].pc, vecs[v].inst, 1);
         check("vec_valid", {31'b0, dc_valid_out}, 32'd1);
         check("vec_pc", dc_pc_out, vecs[v].pc);
         check("vec_inst", dc_inst_out, vecs[v].inst);
         check("vec_taken", {31'b0, dc_pred_taken_out}, {31'b0, vecs[v].taken});
         check("vec_pred", dc_pred_pc_out, vecs[v].pred);
         wait_req();
         check("vec_next_addr", mc_addr_out, vecs[v].pred);
      end

      // Fill to DEPTH with the decoder stalled
      flush_with_done(32'h200);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back({NOP, 32'h200 + 32'(i * 4), 1'b0, 32'h204 + 32'(i * 4)});
         serve(32'h200 + 32'(i * 4), NOP, 1);
      end
      saw = 1'b0;
      repeat (10) begin tick(); if (mc_req_out) saw = 1'b1; end
      check("full_no_req", {31'b0, saw}, 32'd0);
      check("full_head_pc", dc_pc_out, 32'h200);
      dc_ready_in = 1'b1;
      tick();
      dc_ready_in = 1'b0;
      exp_q.push_back({NOP, 32'h220, 1'b0, 32'h224});
      serve(32'h220, NOP, 1);
      saw = 1'b0;
      repeat (10) begin tick(); if (mc_req_out) saw = 1'b1; end
      check("refill_no_req", {31'b0, saw}, 32'd0);
      dc_ready_in = 1'b1;
      repeat (12) tick();
      check("fill_drained", 32'(exp_q.size()), 32'd0);
      check("empty_inst_zero", dc_inst_out, 32'd0);
      check("empty_pc_zero", dc_pc_out, 32'd0);

      // Flush in WAIT, response three cycles later is discarded
      wait_req();
      check("disc_old_addr", mc_addr_out, 32'h224);
      flush_in = 1'b1; flush_pc_in = 32'h100;
      tick();
      flush_in = 1'b0;
      check("disc_req", {31'b0, mc_req_out}, 32'd1);
      check("disc_addr", mc_addr_out, 32'h224);
      check("disc_state", {30'b0, fsm_state_out}, 32'd2);
      tick();
      tick();
      mc_done_in = 1'b1; mc_inst_in = NOP;
      tick();
      mc_done_in = 1'b0; mc_inst_in = '0;
      check("disc_valid", {31'b0, dc_valid_out}, 32'd0);
      check("disc_idle", {30'b0, fsm_state_out}, 32'd0);
      wait_req();
      check("disc_next_addr", mc_addr_out, 32'h100);

      // Flush together with done and a pop, three entries queued
      dc_ready_in = 1'b0;
      serve(32'h100, NOP, 1);
      serve(32'h104, NOP, 1);
      serve(32'h108, NOP, 1);
      wait_req();
      mc_done_in = 1'b1; mc_inst_in = NOP; flush_in = 1'b1; flush_pc_in = 32'h300;
      mon_en = 1'b0; dc_ready_in = 1'b1;
      check("fd_pre_valid", {31'b0, dc_valid_out}, 32'd1);
      tick();
      mc_done_in = 1'b0; flush_in = 1'b0; dc_ready_in = 1'b0; mon_en = 1'b1;
      check("fd_valid", {31'b0, dc_valid_out}, 32'd0);
      check("fd_state", {30'b0, fsm_state_out}, 32'd0);
      wait_req();
      check("fd_next_addr", mc_addr_out, 32'h300);

      // rdy_in low mid-WAIT with entries queued; flush ignored while stalled
      exp_q.push_back({NOP, 32'h300, 1'b0, 32'h304});
      serve(32'h300, NOP, 1);
      exp_q.push_back({NOP, 32'h304, 1'b0, 32'h308});
      serve(32'h304, NOP, 1);
      wait_req();
      rdy_in = 1'b0; dc_ready_in = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin flush_in = 1'b1; flush_pc_in = 32'h500; end
         tick();
         flush_in = 1'b0;
         check("stall_valid", {31'b0, dc_valid_out}, 32'd0);
         check("stall_req", {31'b0, mc_req_out}, 32'd1);
         check("stall_addr", mc_addr_out, 32'h308);
      end
      rdy_in = 1'b1;
      exp_q.push_back({NOP, 32'h308, 1'b0, 32'h30C});
      serve(32'h308, NOP, 1);
      repeat (3) tick();
      check("stall_drained", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset mid-WAIT with one entry queued
      dc_ready_in = 1'b0;
      serve(32'h30C, NOP, 1);
      wait_req();
      #3;
      rst_n_in = 1'b0;
      #1;
      check("arst_req", {31'b0, mc_req_out}, 32'd0);
      check("arst_addr", mc_addr_out, 32'd0);
      check("arst_valid", {31'b0, dc_valid_out}, 32'd0);
      check("arst_pc", dc_pc_out, 32'd0);
      check("arst_inst", dc_inst_out, 32'd0);
      check("arst_taken", {31'b0, dc_pred_taken_out}, 32'd0);
      check("arst_pred", dc_pred_pc_out, 32'd0);
      check("arst_state", {30'b0, fsm_state_out}, 32'd0);
      tick();
      rst_n_in = 1'b1;
      wait_req();
      check("arst_next_addr", mc_addr_out, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
